// File: rtl/cpu_state_sequencer_if.sv
// cpu_state_sequencer_if: control-unit/memory handshake and status bundle around the CPU state sequencer.
// CPU_PERF_COUNT_EN adds the cycle_count and instr_count performance counters.
interface cpu_state_sequencer_if #(parameter int STATE_W = 4);
   logic [5:0]         opcode;
   logic               mem_read;
   logic               mem_write;
   logic               waitrequest;
   logic [31:0]        pc_next;
   logic [STATE_W-1:0] state;
   logic               stall;
   logic               advance;
   logic               active;
   logic               fault;
`ifdef CPU_PERF_COUNT_EN
   logic [31:0]        cycle_count;
   logic [31:0]        instr_count;
`endif
   modport master (
      output opcode, mem_read, mem_write, waitrequest, pc_next,
      input  state, stall, advance, active, fault
`ifdef CPU_PERF_COUNT_EN
      , cycle_count, instr_count
`endif
   );
   modport slave (
      input  opcode, mem_read, mem_write, waitrequest, pc_next,
      output state, stall, advance, active, fault
`ifdef CPU_PERF_COUNT_EN
      , cycle_count, instr_count
`endif
   );
endinterface

// File: rtl/cpu_state_sequencer.sv
// cpu_state_sequencer: multi-cycle FETCH/DECODE/EXEC1/EXEC2/HALT sequencer with memory stall and fault detection.
// CPU_PERF_COUNT_EN adds free-running cycle and retired-instruction counters.
module cpu_state_sequencer #(
   parameter int          STATE_W   = 4,
   parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
   input logic clk,
   input logic reset,
   cpu_state_sequencer_if.slave s
);
   typedef enum logic [2:0] {
      HALT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC1  = 3'd3,
      EXEC2  = 3'd4
   } state_t;
   state_t st;
   logic   legal;
   assign legal     = s.opcode inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
   assign s.stall   = (s.mem_read | s.mem_write) & s.waitrequest;
   assign s.advance = (st != HALT) & ~s.stall;
   assign s.state   = STATE_W'(st);
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= FETCH;
         s.active <= 1'b1;
         s.fault  <= 1'b0;
`ifdef CPU_PERF_COUNT_EN
         s.cycle_count <= 32'd0;
         s.instr_count <= 32'd0;
`endif
      end else begin
         if (!s.stall) begin
            case (st)
               HALT:   st <= HALT;
               FETCH:  st <= DECODE;
               DECODE: st <= EXEC1;
               EXEC1: begin
                  st <= legal ? EXEC2 : HALT;
                  if (!legal) begin
                     s.fault  <= 1'b1;
                     s.active <= 1'b0;
                  end
               end
               EXEC2: begin
                  st <= (s.pc_next == HALT_ADDR) ? HALT : FETCH;
                  if (s.pc_next == HALT_ADDR) s.active <= 1'b0;
               end
               // unreachable encodings are treated as a corrupted sequencer
               default: begin
                  st       <= HALT;
                  s.fault  <= 1'b1;
                  s.active <= 1'b0;
               end
            endcase
         end
`ifdef CPU_PERF_COUNT_EN
         if (s.active) s.cycle_count <= s.cycle_count + 32'd1;
         if (st == EXEC2 && s.advance) s.instr_count <= s.instr_count + 32'd1;
`endif
      end
   end
endmodule

// File: tb/tb_cpu_state_sequencer.sv
// tb_cpu_state_sequencer: directed self-checking bench for cpu_state_sequencer.
// Define CPU_PERF_COUNT_EN to also check the performance counters.
module tb_cpu_state_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   npass = 0;
   int   ntotal = 0;
   int   nfail = 0;
   cpu_state_sequencer_if #(.STATE_W(4)) bus ();
   cpu_state_sequencer #(.STATE_W(4), .HALT_ADDR(32'h0)) dut (.clk(clk), .reset(reset), .s(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [3:0] st, input logic act, input logic flt);
      chk({tag, "_state"}, 32'(bus.state), 32'(st));
      chk({tag, "_active"}, 32'(bus.active), 32'(act));
      chk({tag, "_fault"}, 32'(bus.fault), 32'(flt));
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] cyc, input logic [31:0] ins);
`ifdef CPU_PERF_COUNT_EN
      chk({tag, "_cycles"}, bus.cycle_count, cyc);
      chk({tag, "_instrs"}, bus.instr_count, ins);
`else
      if (cyc === ins && cyc !== cyc) $display("unreachable");
`endif
   endtask

   initial begin
      reset = 1'b1;
      bus.opcode = 6'b000000;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.waitrequest = 1'b0;
      bus.pc_next = 32'h4;
      tick();
      chk_st("reset", 4'd1, 1'b1, 1'b0);
      chk_cnt("reset", 32'd0, 32'd0);
      reset = 1'b0;
      #1;
      chk("fetch_stall", 32'(bus.stall), 32'd0);
      chk("fetch_adv", 32'(bus.advance), 32'd1);
      tick(); chk_st("seq_decode", 4'd2, 1'b1, 1'b0); chk("seq_adv2", 32'(bus.advance), 32'd1);
      tick(); chk_st("seq_exec1", 4'd3, 1'b1, 1'b0); chk("seq_adv3", 32'(bus.advance), 32'd1);
      tick(); chk_st("seq_exec2", 4'd4, 1'b1, 1'b0); chk("seq_adv4", 32'(bus.advance), 32'd1);
      tick(); chk_st("seq_fetch", 4'd1, 1'b1, 1'b0);
      chk_cnt("one_instr", 32'd4, 32'd1);
      tick(); tick(); tick();
      chk("i2_exec2", 32'(bus.state), 32'd4);
      tick(); chk("i2_fetch", 32'(bus.state), 32'd1);
      tick(); tick(); tick();
      chk("i3_exec2", 32'(bus.state), 32'd4);
      bus.pc_next = 32'h0;
      tick();
      chk_st("halt", 4'd0, 1'b0, 1'b0);
      chk_cnt("halt", 32'd12, 32'd3);
      for (int i = 0; i < 10; i++) begin
         bus.opcode = 6'($urandom);
         bus.mem_read = 1'($urandom);
         bus.mem_write = 1'($urandom);
         bus.waitrequest = 1'($urandom);
         bus.pc_next = $urandom;
         tick();
         chk("halt_hold", 32'(bus.state), 32'd0);
         chk("halt_active", 32'(bus.active), 32'd0);
         chk("halt_adv", 32'(bus.advance), 32'd0);
      end
      chk_cnt("halt_frozen", 32'd12, 32'd3);

      bus.opcode = 6'b000000; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.waitrequest = 1'b0; bus.pc_next = 32'h4;
      reset = 1'b1; tick(); reset = 1'b0;
      chk_st("reset2", 4'd1, 1'b1, 1'b0);
      bus.mem_read = 1'b1; bus.waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("fstall_stall", 32'(bus.stall), 32'd1);
         chk("fstall_adv", 32'(bus.advance), 32'd0);
         tick();
         chk("fstall_state", 32'(bus.state), 32'd1);
      end
      bus.waitrequest = 1'b0;
      #1;
      chk("fstall_release", 32'(bus.advance), 32'd1);
      bus.mem_read = 1'b0;
      tick(); chk("fstall_decode", 32'(bus.state), 32'd2);
      bus.mem_write = 1'b1; bus.waitrequest = 1'b1;
      tick(); chk("decode_req_hold", 32'(bus.state), 32'd2);
      bus.mem_write = 1'b0; bus.waitrequest = 1'b0;
      tick(); chk("to_exec1", 32'(bus.state), 32'd3);
      bus.opcode = 6'b001000; bus.mem_read = 1'b1; bus.waitrequest = 1'b1;
      tick(); chk_st("illegal_stalled", 4'd3, 1'b1, 1'b0);
      bus.mem_read = 1'b0; bus.waitrequest = 1'b0;
      tick(); chk_st("illegal", 4'd0, 1'b0, 1'b1);
      tick(); chk_st("fault_sticky", 4'd0, 1'b0, 1'b1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_st("fault_clear", 4'd1, 1'b1, 1'b0);

      bus.opcode = 6'b100011;
      tick(); tick(); tick();
      chk("sw_exec2", 32'(bus.state), 32'd4);
      bus.pc_next = 32'h0; bus.mem_write = 1'b1; bus.waitrequest = 1'b1;
      tick(); chk_st("halt_stalled", 4'd4, 1'b1, 1'b0);
      chk("halt_stalled_adv", 32'(bus.advance), 32'd0);
      bus.waitrequest = 1'b0; bus.mem_write = 1'b0;
      #1; chk("halt_release_adv", 32'(bus.advance), 32'd1);
      tick(); chk_st("halt_after_stall", 4'd0, 1'b0, 1'b0);

      bus.pc_next = 32'h4; bus.opcode = 6'b000000;
      reset = 1'b1; tick(); reset = 1'b0;
      tick(); tick();
      chk("midinst_exec1", 32'(bus.state), 32'd3);
      bus.mem_read = 1'b1; bus.waitrequest = 1'b1; reset = 1'b1;
      tick();
      chk_st("reset_mid_stall", 4'd1, 1'b1, 1'b0);
      chk_cnt("reset_mid_stall", 32'd0, 32'd0);
      reset = 1'b0; bus.mem_read = 1'b0; bus.waitrequest = 1'b0;
      tick(); chk("after_reset_decode", 32'(bus.state), 32'd2);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
